// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte handshake, status pulses and PS/2 pin bundle for the host transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        input  tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        output tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (request-to-send, 11-bit frame, ACK check)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 4800,
    parameter int TIMEOUT_CYCLES = 720000
) (
    input logic          clk,
    input logic          rst,
    ps2_host_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, RELEASE} state_t;
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [9:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic [IW-1:0] inh_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          clk_oe_q, dat_oe_q, done_q, err_q;
    logic          clk_s, dat_s, fe;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fe    = clk_sync_q[2] & ~clk_sync_q[1];

    assign bus.tx_ready   = state_q == IDLE;
    assign bus.busy       = state_q != IDLE;
    assign bus.tx_done    = done_q;
    assign bus.tx_err     = err_q;
    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;

    // Two-flop synchronizers on both pins plus one history flop for clock falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], bus.ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_dat_in};
        end
    end

    // Transmit FSM: inhibit, shift the frame out on device falling edges, check ACK, wait for bus release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.tx_valid) begin
                        shift_q   <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        inh_cnt_q <= IW'(INHIBIT_CYCLES - 1);
                        clk_oe_q  <= 1'b1;
                        state_q   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_q == '0) begin
                        clk_oe_q  <= 1'b0;
                        dat_oe_q  <= 1'b1;
                        to_cnt_q  <= TW'(TIMEOUT_CYCLES - 1);
                        bit_cnt_q <= '0;
                        state_q   <= START;
                    end else begin
                        inh_cnt_q <= inh_cnt_q - IW'(1);
                    end
                end
                default: begin
                    if (to_cnt_q == '0) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q - TW'(1);
                        if (state_q == RELEASE) begin
                            if (clk_s && dat_s) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else if (fe) begin
                            if (state_q == ACK) begin
                                err_q   <= dat_s;
                                state_q <= dat_s ? IDLE : RELEASE;
                            end else begin
                                dat_oe_q  <= ~shift_q[0];
                                shift_q   <= {1'b0, shift_q[9:1]};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                                state_q   <= (bit_cnt_q == 4'd9) ? ACK : SHIFT;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule
